// File: rtl/hub75_stream_loader.sv
// hub75_stream_loader: converts a raster-order valid/ready pixel stream into
// framebuffer writes for the HUB75 driver. It tracks the x/y position, can
// expand RGB565 input, resyncs on malformed frames and raises sticky error flags.
module hub75_stream_loader #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  parameter int rgb565_p = 0,
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [3*bpp_p-1:0]      i_tdata,
  input  logic                    i_tvalid,
  output logic                    o_tready,
  input  logic                    i_tuser,
  input  logic                    i_tlast,
  input  logic                    i_clear_err,
  output logic [addr_width_p-1:0] o_framebuf_wr_addr,
  output logic [3*bpp_p-1:0]      o_framebuf_wr_data,
  output logic                    o_framebuf_wr_en,
  output logic                    o_frame_done,
  output logic                    o_err_line,
  output logic                    o_err_sof
);

  localparam int XW = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int YW = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(hpixel_p - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(vpixel_p - 1);
  localparam logic [addr_width_p-1:0] ROW_STEP = addr_width_p'(hpixel_p);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                  state, state_n;
  logic [XW-1:0]           x, x_n;
  logic [YW-1:0]           y, y_n;
  logic [addr_width_p-1:0] row_base, row_base_n;
  logic [addr_width_p-1:0] addr_n;
  logic [3*bpp_p-1:0]      pix;
  logic                    accept;
  logic                    wr_en_n;
  logic                    done_n;
  logic                    set_line;
  logic                    set_sof;
  logic                    last_col;
  logic                    last_row;

  // Widen a 5-bit colour field to bpp_p bits by repeating it from the MSB down.
  function automatic logic [bpp_p-1:0] expand5(input logic [4:0] f);
    logic [bpp_p-1:0] r;
    for (int i = 0; i < bpp_p; i++) r[i] = f[4 - ((bpp_p - 1 - i) % 5)];
    return r;
  endfunction

  // Widen a 6-bit colour field to bpp_p bits by repeating it from the MSB down.
  function automatic logic [bpp_p-1:0] expand6(input logic [5:0] f);
    logic [bpp_p-1:0] r;
    for (int i = 0; i < bpp_p; i++) r[i] = f[5 - ((bpp_p - 1 - i) % 6)];
    return r;
  endfunction

  generate
    if (rgb565_p != 0) begin : g_rgb565
      assign pix = {expand5(i_tdata[15:11]), expand6(i_tdata[10:5]), expand5(i_tdata[4:0])};
    end else begin : g_passthru
      assign pix = i_tdata;
    end
  endgenerate

  assign o_tready = i_enable & ~rst;
  assign accept   = i_tvalid & o_tready;
  assign last_col = (x == X_LAST);
  assign last_row = (y == Y_LAST);

  // Next-state, position update and write decision for each accepted beat.
  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    row_base_n = row_base;
    addr_n     = row_base + addr_width_p'(x);
    wr_en_n    = 1'b0;
    done_n     = 1'b0;
    set_line   = 1'b0;
    set_sof    = 1'b0;
    if (accept) begin
      if (i_tuser) begin
        // SOF always restarts at pixel (0,0); mid-frame it is also an error.
        set_sof    = (state == ACTIVE);
        wr_en_n    = 1'b1;
        addr_n     = '0;
        x_n        = XW'(1);
        y_n        = '0;
        row_base_n = '0;
        state_n    = ACTIVE;
      end else if (state == ACTIVE) begin
        wr_en_n  = 1'b1;
        set_line = (i_tlast != last_col);
        if (i_tlast || last_col) begin
          if (last_row) begin
            // End of the bottom row: only a full row counts as a finished frame.
            done_n     = last_col;
            x_n        = '0;
            y_n        = '0;
            row_base_n = '0;
            state_n    = WAIT_SOF;
          end else begin
            x_n        = '0;
            y_n        = y + YW'(1);
            row_base_n = row_base + ROW_STEP;
          end
        end else begin
          x_n = x + XW'(1);
        end
      end
    end
  end

  // State, position, registered write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WAIT_SOF;
      x                  <= '0;
      y                  <= '0;
      row_base           <= '0;
      o_framebuf_wr_en   <= 1'b0;
      o_framebuf_wr_addr <= '0;
      o_framebuf_wr_data <= '0;
      o_frame_done       <= 1'b0;
      o_err_line         <= 1'b0;
      o_err_sof          <= 1'b0;
    end else begin
      state            <= state_n;
      x                <= x_n;
      y                <= y_n;
      row_base         <= row_base_n;
      o_framebuf_wr_en <= wr_en_n;
      o_frame_done     <= done_n;
      if (wr_en_n) begin
        o_framebuf_wr_addr <= addr_n;
        o_framebuf_wr_data <= pix;
      end
      o_err_line <= set_line | (o_err_line & ~i_clear_err);
      o_err_sof  <= set_sof  | (o_err_sof  & ~i_clear_err);
    end
  end

endmodule
